// File: rtl/bg_fetch_shifter.sv
// Background tile fetcher and two-plane pixel shifter.
// Fetches map, low-plane and high-plane bytes for each tile column over a
// request/ack handshake, prefetching the next tile while the current one
// shifts out. The head pixel is presented one per pix_adv. The first
// scx_fine pixels of a line are dropped internally to implement fine scroll.
module bg_fetch_shifter (
    input  logic       clk,
    input  logic       reset,
    input  logic       line_start,
    input  logic       line_end,
    input  logic [2:0] scx_fine,
    output logic       vram_req,
    output logic [1:0] vram_sel,
    input  logic       vram_ack,
    input  logic [7:0] vram_data,
    output logic [7:0] tile_idx,
    output logic [4:0] tile_x,
    input  logic       pix_adv,
    output logic       pix_valid,
    output logic       bg_pix_a_7,
    output logic       bg_pix_b_7
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_MAP,
        FETCH_LO,
        FETCH_HI,
        WAIT_LOAD
    } state_t;

    state_t     state;
    logic [7:0] lo_buf;
    logic [7:0] hi_buf;
    logic       data_ready;
    logic [7:0] shift_a;
    logic [7:0] shift_b;
    logic [3:0] count;
    logic [2:0] discard;
    logic       load;
    logic       shift;

    // The shifter reloads only once it is empty; it advances on its own while
    // discarding scroll pixels, otherwise only when downstream consumes.
    assign load      = (count == 4'd0) && data_ready;
    assign shift     = (count != 4'd0) && ((discard != 3'd0) || pix_adv);
    assign pix_valid = (count != 4'd0) && (discard == 3'd0);

    // Head pixel is forced to zero whenever nothing visible is present.
    assign bg_pix_a_7 = pix_valid & shift_a[7];
    assign bg_pix_b_7 = pix_valid & shift_b[7];

    // Request and byte select follow directly from the fetch state.
    always_comb begin
        vram_req = 1'b0;
        vram_sel = 2'd0;
        case (state)
            FETCH_MAP: begin vram_req = 1'b1; vram_sel = 2'd0; end
            FETCH_LO:  begin vram_req = 1'b1; vram_sel = 2'd1; end
            FETCH_HI:  begin vram_req = 1'b1; vram_sel = 2'd2; end
            default:   begin vram_req = 1'b0; vram_sel = 2'd0; end
        endcase
    end

    // Fetch sequencer: walks map/low/high bytes, then parks until the shifter
    // takes the buffered tile. line_start beats line_end and any same-cycle ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tile_idx   <= 8'd0;
            tile_x     <= 5'd0;
            lo_buf     <= 8'd0;
            hi_buf     <= 8'd0;
            data_ready <= 1'b0;
        end else if (line_start) begin
            state      <= FETCH_MAP;
            tile_x     <= 5'd0;
            data_ready <= 1'b0;
        end else if (line_end) begin
            state      <= IDLE;
            data_ready <= 1'b0;
        end else begin
            case (state)
                FETCH_MAP: begin
                    if (vram_ack) begin
                        tile_idx <= vram_data;
                        state    <= FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (vram_ack) begin
                        lo_buf <= vram_data;
                        state  <= FETCH_HI;
                    end
                end
                FETCH_HI: begin
                    if (vram_ack) begin
                        hi_buf     <= vram_data;
                        data_ready <= 1'b1;
                        tile_x     <= tile_x + 5'd1;
                        state      <= WAIT_LOAD;
                    end
                end
                WAIT_LOAD: begin
                    // Buffer is free again once the shifter loads: prefetch next tile.
                    if (load) begin
                        data_ready <= 1'b0;
                        state      <= FETCH_MAP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pixel shifter: loads a full tile when empty, shifts MSB-first, and
    // burns through the fine-scroll discard count before pixels become visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_a <= 8'd0;
            shift_b <= 8'd0;
            count   <= 4'd0;
            discard <= 3'd0;
        end else if (line_start) begin
            count   <= 4'd0;
            discard <= scx_fine;
        end else if (line_end) begin
            count   <= 4'd0;
            discard <= 3'd0;
        end else if (load) begin
            shift_a <= lo_buf;
            shift_b <= hi_buf;
            count   <= 4'd8;
        end else if (shift) begin
            shift_a <= {shift_a[6:0], 1'b0};
            shift_b <= {shift_b[6:0], 1'b0};
            count   <= count - 4'd1;
            if (discard != 3'd0) begin
                discard <= discard - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_bg_fetch_shifter.sv
// Testbench for bg_fetch_shifter: a VRAM responder model feeds tile bytes,
// a scoreboard queue holds the expected visible pixels of each fetched tile,
// and a table of line scenarios plus hand-written timing sequences check it.
module tb_bg_fetch_shifter;

    logic       clk = 1'b0;
    logic       reset;
    logic       line_start;
    logic       line_end;
    logic [2:0] scx_fine;
    logic       vram_req;
    logic [1:0] vram_sel;
    logic       vram_ack;
    logic [7:0] vram_data;
    logic [7:0] tile_idx;
    logic [4:0] tile_x;
    logic       pix_adv;
    logic       pix_valid;
    logic       bg_pix_a_7;
    logic       bg_pix_b_7;

    bg_fetch_shifter dut (
        .clk        (clk),
        .reset      (reset),
        .line_start (line_start),
        .line_end   (line_end),
        .scx_fine   (scx_fine),
        .vram_req   (vram_req),
        .vram_sel   (vram_sel),
        .vram_ack   (vram_ack),
        .vram_data  (vram_data),
        .tile_idx   (tile_idx),
        .tile_x     (tile_x),
        .pix_adv    (pix_adv),
        .pix_valid  (pix_valid),
        .bg_pix_a_7 (bg_pix_a_7),
        .bg_pix_b_7 (bg_pix_b_7)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] scx;
        logic [7:0] map;
        logic [7:0] lo;
        logic [7:0] hi;
        int         delay;
        int         adv;        // 0: always consume, 1: random, 2: never
        logic [1:0] exp_first;  // {b,a} of first visible pixel
        int         exp_run;    // visible pixels in the first tile
    } vec_t;

    vec_t vecs[6];

    int n_checks = 0;
    int n_fail   = 0;

    // Model / scoreboard state
    logic [1:0] sb_q[$];
    int         fetch_k;
    int         skip;
    int         ack_delay;
    int         waited;
    int         adv_mode;
    logic [7:0] cur_map, cur_lo, cur_hi;
    logic       wait_active;
    logic [1:0] held_sel;
    logic       tidx_pending;
    logic [7:0] tidx_exp;
    int         pops;
    int         first_run_pops;
    logic       in_first_run;
    logic       seen_valid;
    logic       got_first;
    logic [1:0] first_pix;
    logic       nxt_ls, nxt_le;
    logic [2:0] nxt_scx;

    logic [1:0] exp_pairs[8];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [1:0] sel, input int k);
        logic [7:0] kk;
        kk = 8'(k);
        case (sel)
            2'd0:    model_byte = cur_map + kk;
            2'd1:    model_byte = cur_lo ^ (kk * 8'h25);
            default: model_byte = cur_hi ^ (kk * 8'h1D);
        endcase
    endfunction

    task automatic model_clear();
        sb_q.delete();
        waited       = 0;
        wait_active  = 1'b0;
        tidx_pending = 1'b0;
        fetch_k      = 0;
        skip         = 0;
    endtask

    // Compare the DUT against the model in the middle of the cycle.
    task automatic monitor();
        if (wait_active) begin
            check("req_held", 32'(vram_req), 1);
            check("sel_held", 32'(vram_sel), 32'(held_sel));
        end
        if (tidx_pending) begin
            check("tile_idx_latch", 32'(tile_idx), 32'(tidx_exp));
            tidx_pending = 1'b0;
        end
        if (pix_valid) begin
            seen_valid = 1'b1;
            if (!got_first) begin
                got_first = 1'b1;
                first_pix = {bg_pix_b_7, bg_pix_a_7};
            end
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pix_extra: valid pixel (b,a)=%b%b with no expected pixel (t=%0t)",
                         bg_pix_b_7, bg_pix_a_7, $time);
            end else begin
                check("pix_head", 32'({bg_pix_b_7, bg_pix_a_7}), 32'(sb_q[0]));
            end
        end else begin
            check("pix_zero", 32'({bg_pix_b_7, bg_pix_a_7}), 0);
            if (seen_valid) in_first_run = 1'b0;
        end
    endtask

    // Drive inputs for the next rising edge and update the model to match.
    task automatic drive();
        logic [7:0] lo_k, hi_k;
        line_start = nxt_ls;
        line_end   = nxt_le;
        scx_fine   = nxt_scx;
        nxt_ls     = 1'b0;
        nxt_le     = 1'b0;
        case (adv_mode)
            0:       pix_adv = 1'b1;
            1:       pix_adv = 1'($urandom_range(0, 1));
            default: pix_adv = 1'b0;
        endcase
        vram_ack    = 1'b0;
        vram_data   = 8'($urandom);
        wait_active = 1'b0;
        if (vram_req && !reset) begin
            if (waited >= ack_delay) begin
                vram_ack  = 1'b1;
                vram_data = model_byte(vram_sel, fetch_k);
                waited    = 0;
            end else begin
                waited++;
                if (!line_start && !line_end) begin
                    wait_active = 1'b1;
                    held_sel    = vram_sel;
                end
            end
        end
        if (line_start || line_end) begin
            sb_q.delete();
            waited = 0;
            if (line_start) begin
                fetch_k        = 0;
                skip           = int'(scx_fine);
                seen_valid     = 1'b0;
                in_first_run   = 1'b1;
                first_run_pops = 0;
                got_first      = 1'b0;
            end
        end else begin
            if (pix_valid && pix_adv && sb_q.size() > 0) begin
                pops++;
                if (in_first_run) first_run_pops++;
                void'(sb_q.pop_front());
            end
            if (vram_ack) begin
                if (vram_sel == 2'd0) begin
                    tidx_pending = 1'b1;
                    tidx_exp     = vram_data;
                end else if (vram_sel == 2'd2) begin
                    lo_k = model_byte(2'd1, fetch_k);
                    hi_k = model_byte(2'd2, fetch_k);
                    for (int i = 7 - skip; i >= 0; i--) sb_q.push_back({hi_k[i], lo_k[i]});
                    skip = 0;
                    fetch_k++;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        drive();
    endtask

    task automatic set_data(input logic [7:0] m, input logic [7:0] l, input logic [7:0] h,
                            input int d, input int a);
        cur_map   = m;
        cur_lo    = l;
        cur_hi    = h;
        ack_delay = d;
        adv_mode  = a;
        pops      = 0;
    endtask

    task automatic end_line();
        nxt_le = 1'b1;
        tick();
        tick();
        check("idle_req", 32'(vram_req), 0);
        check("idle_valid", 32'(pix_valid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        bit timed_out;

        vecs[0] = '{3'd0, 8'h12, 8'hA5, 8'h3C, 0, 0, 2'b01, 8};
        vecs[1] = '{3'd3, 8'h12, 8'hA5, 8'h3C, 0, 0, 2'b10, 5};
        vecs[2] = '{3'd0, 8'h12, 8'hA5, 8'h3C, 4, 0, 2'b01, 8};
        vecs[3] = '{3'd7, 8'h5A, 8'hFF, 8'h00, 1, 1, 2'b01, 1};
        vecs[4] = '{3'd5, 8'h81, 8'h01, 8'h80, 2, 1, 2'b00, 3};
        vecs[5] = '{3'd1, 8'h00, 8'hC3, 8'h96, 0, 1, 2'b01, 7};

        exp_pairs = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b10, 2'b11, 2'b00, 2'b01};

        reset      = 1'b1;
        line_start = 1'b0;
        line_end   = 1'b0;
        scx_fine   = 3'd0;
        vram_ack   = 1'b0;
        vram_data  = 8'd0;
        pix_adv    = 1'b0;
        nxt_ls     = 1'b0;
        nxt_le     = 1'b0;
        nxt_scx    = 3'd0;
        seen_valid = 1'b0;
        got_first  = 1'b0;
        first_pix  = 2'b00;
        in_first_run   = 1'b0;
        first_run_pops = 0;
        held_sel   = 2'd0;
        tidx_exp   = 8'd0;
        set_data(8'h12, 8'hA5, 8'h3C, 0, 0);
        model_clear();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req", 32'(vram_req), 0);
        check("rst_sel", 32'(vram_sel), 0);
        check("rst_tile_idx", 32'(tile_idx), 0);
        check("rst_tile_x", 32'(tile_x), 0);
        check("rst_valid", 32'(pix_valid), 0);
        check("rst_pix", 32'({bg_pix_b_7, bg_pix_a_7}), 0);
        reset = 1'b0;
        repeat (3) tick();
        check("idle_no_req", 32'(vram_req), 0);

        // Exact latency with ack tied high and no scroll
        set_data(8'h12, 8'hA5, 8'h3C, 0, 0);
        nxt_ls = 1'b1; nxt_scx = 3'd0;
        tick();                                   // cycle 0
        tick();                                   // cycle 1
        check("lat_c1_req", 32'(vram_req), 1);
        check("lat_c1_sel", 32'(vram_sel), 0);
        tick();                                   // cycle 2
        check("lat_c2_req", 32'(vram_req), 1);
        check("lat_c2_sel", 32'(vram_sel), 1);
        check("lat_tile_idx", 32'(tile_idx), 32'h12);
        tick();                                   // cycle 3
        check("lat_c3_req", 32'(vram_req), 1);
        check("lat_c3_sel", 32'(vram_sel), 2);
        tick();                                   // cycle 4
        check("lat_c4_req", 32'(vram_req), 0);
        check("lat_c4_valid", 32'(pix_valid), 0);
        check("lat_tile_x", 32'(tile_x), 1);
        for (int i = 0; i < 8; i++) begin         // cycles 5..12
            tick();
            check("lat_pix_valid", 32'(pix_valid), 1);
            check("lat_pix_pair", 32'({bg_pix_b_7, bg_pix_a_7}), 32'(exp_pairs[i]));
        end
        tick();                                   // cycle 13: bubble
        check("lat_bubble", 32'(pix_valid), 0);
        tick();                                   // cycle 14: next tile
        check("lat_next_tile", 32'(pix_valid), 1);
        end_line();

        // Downstream stalled: head holds, next tile fetched, fetcher parks
        set_data(8'h12, 8'hA5, 8'h3C, 0, 2);
        nxt_ls = 1'b1; nxt_scx = 3'd0;
        tick();
        repeat (5) tick();
        check("stall_valid0", 32'(pix_valid), 1);
        check("stall_head0", 32'({bg_pix_b_7, bg_pix_a_7}), 32'b01);
        repeat (20) tick();
        check("stall_valid", 32'(pix_valid), 1);
        check("stall_head", 32'({bg_pix_b_7, bg_pix_a_7}), 32'b01);
        check("stall_parked_req", 32'(vram_req), 0);
        check("stall_tile_x", 32'(tile_x), 2);
        check("stall_queued", 32'(sb_q.size()), 16);
        end_line();

        // Asynchronous reset mid-fetch (FETCH_LO, five pixels left)
        set_data(8'h12, 8'hA5, 8'h3C, 2, 0);
        nxt_ls = 1'b1; nxt_scx = 3'd0;
        tick();
        repeat (14) tick();
        check("pre_rst_sel", 32'(vram_sel), 1);
        check("pre_rst_valid", 32'(pix_valid), 1);
        #2 reset = 1'b1;
        #1;
        check("arst_req", 32'(vram_req), 0);
        check("arst_sel", 32'(vram_sel), 0);
        check("arst_tile_idx", 32'(tile_idx), 0);
        check("arst_tile_x", 32'(tile_x), 0);
        check("arst_valid", 32'(pix_valid), 0);
        check("arst_pix", 32'({bg_pix_b_7, bg_pix_a_7}), 0);
        model_clear();
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_req", 32'(vram_req), 0);
        end

        // line_start while fetching the high plane with three pixels left
        set_data(8'h12, 8'hA5, 8'h3C, 1, 0);
        nxt_ls = 1'b1; nxt_scx = 3'd0;
        tick();
        repeat (12) tick();
        nxt_ls = 1'b1; nxt_scx = 3'd0;
        tick();                                   // cycle 13, line_start + ack
        check("restart_pre_sel", 32'(vram_sel), 2);
        check("restart_pre_valid", 32'(pix_valid), 1);
        tick();
        check("restart_valid", 32'(pix_valid), 0);
        check("restart_req", 32'(vram_req), 1);
        check("restart_sel", 32'(vram_sel), 0);
        check("restart_tile_x", 32'(tile_x), 0);
        repeat (3) tick();
        nxt_ls = 1'b1; nxt_le = 1'b1; nxt_scx = 3'd0;
        tick();
        tick();
        check("ls_wins_req", 32'(vram_req), 1);
        check("ls_wins_sel", 32'(vram_sel), 0);
        end_line();

        // Table of line scenarios checked against the scoreboard
        for (int v = 0; v < 6; v++) begin
            set_data(vecs[v].map, vecs[v].lo, vecs[v].hi, vecs[v].delay, vecs[v].adv);
            nxt_ls  = 1'b1;
            nxt_scx = vecs[v].scx;
            tick();
            target    = 16 - int'(vecs[v].scx);
            timed_out = 1'b1;
            for (int c = 0; c < 600; c++) begin
                if (pops >= target) begin
                    timed_out = 1'b0;
                    break;
                end
                tick();
            end
            if (timed_out) begin
                n_checks++;
                n_fail++;
                $display("FAIL vec%0d_timeout: consumed %0d pixels, required %0d", v, pops, target);
            end
            check($sformatf("vec%0d_first_pix", v), 32'(first_pix), 32'(vecs[v].exp_first));
            check($sformatf("vec%0d_first_run", v), 32'(first_run_pops), 32'(vecs[v].exp_run));
            end_line();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
